cdc_hs_rx_arbiter: RTL and testbench

//  Destination-side controller for multi-bit clock-domain crossings using a 4-phase req/ack handshake.

---
 rtl/cdc_hs_rx_arbiter.sv | 144 ++++++++++++++
 tb/tb_cdc_hs_rx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_rx_arbiter.sv
// Destination-side receiver for 4-phase req/ack clock-domain crossings.
// Each channel's request level passes through its own synchronizer chain.
// Pending channels are granted round-robin. The granted channel's held data
// bus is captured and offered on a valid/ready port. The level ack returns to
// the source after the consumer accepts the word.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no word held; grant the next eligible channel if any
// ST_VALID | captured word presented; wait for out_ready_i, then ack

module cdc_hs_rx_arbiter #(
    parameter int N_CH      = 4,
    parameter int DW        = 32,
    parameter int MF_SYNC_N = 4,
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 dest_clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      src_req_i,
    input  logic [N_CH*DW-1:0]   src_data_i,
    output logic [N_CH-1:0]      src_ack_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DW-1:0]        out_data_o,
    output logic [CW-1:0]        out_ch_o,
    output logic                 busy_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_VALID = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [MF_SYNC_N-1:0]   sync_q [N_CH];
    logic [N_CH-1:0]        sreq;
    logic [N_CH-1:0]        elig;
    logic                   any_elig;
    logic [CW-1:0]          grant_idx;
    logic [CW-1:0]          ptr_q, ptr_d;
    logic [N_CH-1:0]        ack_q, ack_d;
    logic                   out_valid_q, out_valid_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic [CW-1:0]          out_ch_q, out_ch_d;

    // A channel already acked is not eligible again until its request drops.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            sreq[c] = sync_q[c][MF_SYNC_N-1];
        end
        elig = sreq & ~ack_q;
    end

    // Round-robin search: walk offsets from the highest down so that the
    // eligible channel closest to (at or after) the pointer wins.
    always_comb begin
        int idx;
        idx       = 0;
        any_elig  = 1'b0;
        grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (elig[idx]) begin
                any_elig  = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    // State register, synchronizer chains and datapath registers.
    always_ff @(posedge dest_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sync_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            for (int c = 0; c < N_CH; c++) begin
                sync_q[c] <= {sync_q[c][MF_SYNC_N-2:0], src_req_i[c]};
            end
        end
    end

    // Next state: grant in IDLE, wait for acceptance in VALID. Ack release
    // follows the synchronized request regardless of state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ack_d       = ack_q;

        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d     = ST_VALID;
                    out_valid_d = 1'b1;
                    out_data_d  = src_data_i[grant_idx*DW +: DW];
                    out_ch_d    = grant_idx;
                    ptr_d       = (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + CW'(1);
                end
            end
            ST_VALID: begin
                if (out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int c = 0; c < N_CH; c++) begin
            if ((state_q == ST_VALID) && out_ready_i && (out_ch_q == CW'(c))) begin
                ack_d[c] = 1'b1;
            end
            if (!sreq[c]) begin
                ack_d[c] = 1'b0;
            end
        end
    end

    // Outputs come straight from registers; busy mirrors the VALID state.
    always_comb begin
        src_ack_o   = ack_q;
        out_valid_o = out_valid_q;
        out_data_o  = out_data_q;
        out_ch_o    = out_ch_q;
        busy_o      = (state_q == ST_VALID);
    end

endmodule

// File: tb/tb_cdc_hs_rx_arbiter.sv
// Directed bench for cdc_hs_rx_arbiter (N_CH=4, DW=32, MF_SYNC_N=4).
// Inputs change and outputs are sampled on the falling edge.

module tb_cdc_hs_rx_arbiter;

    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int SN   = 4;
    localparam int CW   = 2;

    logic                dest_clk;
    logic                rst;
    logic [N_CH-1:0]     src_req;
    logic [N_CH*DW-1:0]  src_data;
    logic [N_CH-1:0]     src_ack;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic [CW-1:0]       out_ch;
    logic                busy;

    int n_checks;
    int n_errors;

    cdc_hs_rx_arbiter #(.N_CH(N_CH), .DW(DW), .MF_SYNC_N(SN)) dut (
        .dest_clk    (dest_clk),
        .rst         (rst),
        .src_req_i   (src_req),
        .src_data_i  (src_data),
        .src_ack_o   (src_ack),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .busy_o      (busy)
    );

    initial dest_clk = 1'b0;
    always #5 dest_clk = ~dest_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge dest_clk);
        @(negedge dest_clk);
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] d);
        src_data[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    logic [DW-1:0] held_data;
    logic [CW-1:0] held_ch;
    logic [DW-1:0] vec [N_CH];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        src_req   = '0;
        src_data  = '0;
        out_ready = 1'b1;
        vec[0] = 32'h1111_0000;
        vec[1] = 32'h2222_1111;
        vec[2] = 32'h3333_2222;
        vec[3] = 32'h4444_3333;

        // Reset state
        step(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_ack",   src_ack,   0);
        chk("rst_busy",  busy,      0);
        chk("rst_data",  out_data,  0);
        chk("rst_ch",    out_ch,    0);
        rst = 1'b0;

        // 1: single request on ch2, latency to valid, ack and ack release
        set_data(2, 32'hDEAD_BEEF);
        src_req[2] = 1'b1;
        step(4);
        chk("t1_valid_e4", out_valid, 0);
        step(1);
        chk("t1_valid_e5", out_valid, 1);
        chk("t1_ch",       out_ch,    2);
        chk("t1_data",     out_data,  32'hDEAD_BEEF);
        chk("t1_busy",     busy,      1);
        chk("t1_ack_e5",   src_ack,   4'b0000);
        step(1);
        chk("t1_ack_e6",   src_ack,   4'b0100);
        chk("t1_valid_e6", out_valid, 0);
        chk("t1_busy_e6",  busy,      0);
        src_req[2] = 1'b0;
        step(4);
        chk("t1_ack_hold", src_ack,   4'b0100);
        step(1);
        chk("t1_ack_rel",  src_ack,   4'b0000);

        // 2: all four request together, round-robin from ptr 0
        do_reset();
        for (int c = 0; c < N_CH; c++) set_data(c, vec[c]);
        src_req = 4'b1111;
        step(5);
        for (int k = 0; k < N_CH; k++) begin
            chk($sformatf("t2_valid%0d", k), out_valid, 1);
            chk($sformatf("t2_ch%0d", k),    out_ch,    k);
            chk($sformatf("t2_data%0d", k),  out_data,  vec[k]);
            step(1);
            chk($sformatf("t2_ack%0d", k),   src_ack,   (4'b0001 << (k + 1)) - 4'b0001);
            chk($sformatf("t2_idle%0d", k),  out_valid, 0);
            step(1);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2_no_regrant", out_valid, 0);
            step(1);
        end
        src_req = '0;
        step(5);
        chk("t2_ack_rel", src_ack, 0);

        // 3: backpressure holds the word, a single ready cycle acks once
        out_ready = 1'b0;
        set_data(1, 32'hCAFE_F00D);
        src_req[1] = 1'b1;
        step(5);
        chk("t3_valid", out_valid, 1);
        chk("t3_ch",    out_ch,    1);
        chk("t3_data",  out_data,  32'hCAFE_F00D);
        held_data = out_data;
        held_ch   = out_ch;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data",  out_data,  32'hCAFE_F00D);
            chk("t3_hold_ch",    out_ch,    1);
            chk("t3_hold_ack",   src_ack,   0);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t3_ack_once",  src_ack,   4'b0010);
        chk("t3_valid_off", out_valid, 0);

        // 5: request held high after ack is never re-granted
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("t5_no_regrant", out_valid, 0);
            chk("t5_ack_held",   src_ack,   4'b0010);
        end
        src_req[1] = 1'b0;
        out_ready  = 1'b1;
        step(5);
        chk("t5_ack_rel", src_ack, 0);

        // 4: ch1 and ch3 re-request in full 4-phase rounds, pointer wraps after ch3
        do_reset();
        for (int r = 0; r < 2; r++) begin
            set_data(1, 32'hA100_0000 + r);
            set_data(3, 32'hA300_0000 + r);
            src_req = 4'b1010;
            step(5);
            chk("t4_ch_a",   out_ch,   1);
            chk("t4_data_a", out_data, 32'hA100_0000 + r);
            step(1);
            chk("t4_ack_a",  src_ack,  4'b0010);
            step(1);
            chk("t4_valid_b", out_valid, 1);
            chk("t4_ch_b",    out_ch,    3);
            chk("t4_data_b",  out_data,  32'hA300_0000 + r);
            step(1);
            chk("t4_ack_b",   src_ack,   4'b1010);
            src_req = '0;
            step(5);
            chk("t4_ack_rel", src_ack,   0);
        end

        // 6: reset while VALID discards the word; held request is redelivered
        out_ready = 1'b0;
        set_data(0, 32'h0BAD_F00D);
        src_req[0] = 1'b1;
        step(5);
        chk("t6_valid_pre", out_valid, 1);
        chk("t6_ch_pre",    out_ch,    0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_valid_rst", out_valid, 0);
        chk("t6_ack_rst",   src_ack,   0);
        chk("t6_busy_rst",  busy,      0);
        chk("t6_data_rst",  out_data,  0);
        step(4);
        chk("t6_valid_e4",  out_valid, 0);
        step(1);
        chk("t6_valid_e5",  out_valid, 1);
        chk("t6_ch_e5",     out_ch,    0);
        chk("t6_data_e5",   out_data,  32'h0BAD_F00D);
        out_ready = 1'b1;
        step(1);
        chk("t6_ack",       src_ack,   4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
